// File: rtl/ifu_pkg.sv
// Shared types and default sizes for the instruction-fetch unit.
// The optional fetch timeout is enabled with the IFU_TIMEOUT_EN macro.
package ifu_pkg;

    localparam int IFU_ADDR_W      = 32;
    localparam int IFU_DATA_W      = 32;
    localparam int IFU_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Counts consecutive request cycles without an ack and pulses timeout on the
// TIMEOUT_CYC-th one. Only instantiated when IFU_TIMEOUT_EN is defined.
module ifu_timeout_ctr
    import ifu_pkg::*;
#(
    parameter int TIMEOUT_CYC = IFU_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ack,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             waiting;

    assign waiting = active && !ack;
    assign timeout = waiting && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Any cycle outside REQ (or an ack) restarts the count, so entry into REQ
    // always begins from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (waiting && !timeout) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: req/ack fetch from instruction memory, output holding register
// toward decode, and the PC advance enable. Optional timeout: IFU_TIMEOUT_EN.
module ifetch_unit
    import ifu_pkg::*;
#(
    parameter int ADDR_W      = IFU_ADDR_W,
    parameter int DATA_W      = IFU_DATA_W,
    parameter int TIMEOUT_CYC = IFU_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_index,
    input  logic              pc_valid,
    input  logic              flush,
    output logic              pc_write_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);

    ifu_state_e state, state_nxt;
    logic       kill, kill_nxt;
    logic       load_addr;
    logic       capture;
    logic       transfer;
    logic       timeout;

    assign imem_req    = (state == REQ);
    assign instr_valid = (state == HOLD);
    assign transfer    = instr_valid && instr_ready && !flush;
    assign pc_write_en = !reset && (transfer || flush);

`ifdef IFU_TIMEOUT_EN
    ifu_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .active  (imem_req),
        .ack     (imem_ack),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else if (timeout) begin
            fetch_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout            = 1'b0;
    assign fetch_err          = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, otherwise paths
    // that leave one unassigned infer a latch.
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        load_addr = 1'b0;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                // A redirect in IDLE changes nothing; the next fetch waits.
                if (pc_valid && !flush) begin
                    load_addr = 1'b1;
                    state_nxt = REQ;
                end
            end

            REQ: begin
                if (imem_ack) begin
                    if (kill || flush) begin
                        kill_nxt  = 1'b0;
                        load_addr = pc_valid;
                        state_nxt = pc_valid ? REQ : IDLE;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (timeout) begin
                    kill_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (flush) begin
                    // The request cannot be withdrawn; remember to drop its data.
                    kill_nxt = 1'b1;
                end
            end

            HOLD: begin
                if (flush || instr_ready) begin
                    load_addr = pc_valid;
                    state_nxt = pc_valid ? REQ : IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                kill_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_addr <= '0;
            instr     <= '0;
            instr_pc  <= '0;
        end else begin
            if (load_addr) begin
                imem_addr <= pc_index;
            end
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= imem_addr;
            end
        end
    end

endmodule
